// File: rtl/dbg_pkg.sv
// Shared types and constants for the state dump streamer.
// Header layout: magic, drop count, sequence number.
package dbg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_PCW,
    ST_REG
  } state_e;

  localparam logic [7:0] DUMP_MAGIC = 8'hA5;
  localparam int DUMP_NREG = 32;
  localparam int DUMP_WORDS = DUMP_NREG + 2;

  localparam int HDR_MAGIC_LSB = 24;
  localparam int HDR_DROP_LSB = 16;
  localparam int HDR_SEQ_LSB = 0;

  function automatic logic [31:0] dump_hdr(
    input logic [7:0] drop,
    input logic [15:0] seq
  );
    logic [31:0] h;
    h = '0;
    h[HDR_MAGIC_LSB +: 8] = DUMP_MAGIC;
    h[HDR_DROP_LSB +: 8] = drop;
    h[HDR_SEQ_LSB +: 16] = seq;
    return h;
  endfunction

endpackage

// File: rtl/dump_word_mux.sv
// Output holding register for the dump stream.
// The word source follows the state the FSM is leaving.
module dump_word_mux
  import dbg_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            load_i,
  input  state_e          state_i,
  input  logic [XLEN-1:0] hdr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] rf_data_i,
  output logic [XLEN-1:0] data_o
);

  logic [XLEN-1:0] data_q;
  logic [XLEN-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (load_i) begin
      unique case (state_i)
        ST_IDLE: data_d = hdr_i;
        ST_HDR:  data_d = pc_i;
        ST_PCW:  data_d = rf_data_i;
        ST_REG:  data_d = rf_data_i;
        default: data_d = data_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/state_dump_tx.sv
// Halts the CPU and streams one framed PC/register snapshot.
// Frame: header, PC, x0..x31 over a valid/ready word stream.
module state_dump_tx
  import dbg_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              snap_i,
  input  logic [XLEN-1:0]   pc_i,
  output logic [REG_AW-1:0] rf_addr_o,
  input  logic [XLEN-1:0]   rf_data_i,
  output logic              halt_o,
  output logic              busy_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  output logic [XLEN-1:0]   tx_data_o,
  output logic              tx_last_o
);

  localparam logic [REG_AW-1:0] LAST_IDX = REG_AW'(NREG - 1);

  state_e state_q, state_d;
  logic [15:0] seq_q, seq_d;
  logic [7:0] drop_q, drop_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [REG_AW-1:0] idx_q, idx_d;
  logic valid_q, valid_d;
  logic last_q, last_d;
  logic load;
  logic xfer;
  logic busy;

  assign xfer = valid_q & tx_ready_i;
  assign busy = (state_q != ST_IDLE);

  always_comb begin
    state_d = state_q;
    seq_d = seq_q;
    drop_d = drop_q;
    pc_d = pc_q;
    idx_d = idx_q;
    valid_d = valid_q;
    last_d = last_q;
    load = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (snap_i) begin
          pc_d = pc_i;
          valid_d = 1'b1;
          last_d = 1'b0;
          load = 1'b1;
          state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        if (xfer) begin
          load = 1'b1;
          drop_d = '0;
          state_d = ST_PCW;
        end
      end
      ST_PCW: begin
        if (xfer) begin
          load = 1'b1;
          idx_d = '0;
          last_d = (LAST_IDX == '0);
          state_d = ST_REG;
        end
      end
      ST_REG: begin
        if (xfer) begin
          if (idx_q != LAST_IDX) begin
            load = 1'b1;
            idx_d = idx_q + REG_AW'(1);
            last_d = (idx_d == LAST_IDX);
          end else begin
            valid_d = 1'b0;
            last_d = 1'b0;
            seq_d = seq_q + 16'd1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // applied after the header clear so a coincident request counts as 1
    if (busy && snap_i && drop_d != 8'hFF) begin
      drop_d = drop_d + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      seq_q <= '0;
      drop_q <= '0;
      pc_q <= '0;
      idx_q <= '0;
      valid_q <= 1'b0;
      last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      seq_q <= seq_d;
      drop_q <= drop_d;
      pc_q <= pc_d;
      idx_q <= idx_d;
      valid_q <= valid_d;
      last_q <= last_d;
    end
  end

  // look one register ahead so the next word is ready at transfer
  always_comb begin
    rf_addr_o = '0;
    if (state_q == ST_REG && idx_q != LAST_IDX) begin
      rf_addr_o = idx_q + REG_AW'(1);
    end
  end

  dump_word_mux #(
    .XLEN(XLEN)
  ) u_mux (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .load_i   (load),
    .state_i  (state_q),
    .hdr_i    (XLEN'(dump_hdr(drop_q, seq_q))),
    .pc_i     (pc_q),
    .rf_data_i(rf_data_i),
    .data_o   (tx_data_o)
  );

  assign halt_o = busy;
  assign busy_o = busy;
  assign tx_valid_o = valid_q;
  assign tx_last_o = last_q;

endmodule

// File: doc/state_dump_tx.md
Name: state_dump_tx

Overview:
- Hardware counterpart of the bench-side PC/register dump.
- On a snapshot request, freezes the CPU via `halt_o` and captures PC.
- Streams one framed snapshot over a valid/ready word interface: header, PC, x0..x31.
- Sits beside CPU top. It reads the register file through a dedicated combinational read port, so the dump works in silicon and in test alike.

Parameters:
- XLEN, 32, data word width (PC, registers, stream words)
- NREG, 32, number of architectural registers dumped
- REG_AW, 5, register index width, clog2(NREG)

Ports:
- `clk_i` input 1: clock
- `rst_n_i` input 1: asynchronous active-low reset
- `snap_i` input 1: snapshot request, sampled each posedge
- `pc_i` input XLEN: current CPU PC
- `rf_addr_o` output REG_AW: register file debug read address
- `rf_data_i` input XLEN: combinational read data for `rf_addr_o`
- `halt_o` output 1: CPU stall; high while a frame is in flight
- `busy_o` output 1: frame in progress
- `tx_valid_o` output 1: stream word valid
- `tx_ready_i` input 1: sink ready
- `tx_data_o` output XLEN: stream word
- `tx_last_o` output 1: marks final word of frame (x31)

Behaviour:
- Reset (async, `rst_n_i`=0):
  - `tx_valid_o`, `tx_last_o`, `halt_o`, `busy_o` = 0.
  - `tx_data_o`, `rf_addr_o` = 0.
  - seq = 0, drop = 0, state = IDLE.
- Reset mid-frame aborts the frame. Outputs drop immediately. The next frame starts with seq 0.
- Frame format, 34 words:
  - W0 header = {8'hA5, drop[7:0], seq[15:0]}.
  - W1 = PC captured at accept.
  - W2..W33 = x0..x31. `tx_last_o`=1 only on W33.
- Handshake:
  - Transfer occurs on posedge when `tx_valid_o` && `tx_ready_i`.
  - While valid && !ready, `tx_data_o` and `tx_last_o` hold stable.
  - `tx_valid_o` never drops before transfer.
- States: IDLE -> HDR -> PCW -> REG -> IDLE.
  - IDLE: `snap_i`=1 at posedge -> capture `pc_i`, set `halt_o`=`busy_o`=1, load header, `tx_valid_o`=1, go HDR. Latency is 1 cycle from request to first valid word.
  - HDR: on transfer -> load PC word, clear drop, go PCW.
  - PCW: on transfer -> load `rf_data_i` (`rf_addr_o`=0), idx=0, go REG.
  - REG: `rf_addr_o` = idx+1 while idx<31, so the next word is presented combinationally. On transfer with idx<31 -> load `rf_data_i`, idx++. On transfer with idx=31 -> `tx_valid_o`=0, `halt_o`=0, `busy_o`=0, seq++, go IDLE.
- Throughput: with `tx_ready_i` held high, the frame takes 34 cycles. The earliest next accept is the cycle after IDLE is entered. Back-to-back `snap_i` therefore starts a new frame every 35 cycles.
- `snap_i` while busy: the request is dropped and drop increments, saturating at 255.
- `snap_i` on the same cycle the header transfers: drop clears first, then increments, so the next header reports drop=1.
- seq is 16-bit and wraps 0xFFFF -> 0x0000.
- `halt_o` stays high for the whole frame, so register contents are a consistent snapshot. The CPU is required to hold architectural state while `halt_o`=1.
- x0 is dumped as read (expected 0); the block does not force it.

Decomposition:
- Shared package `dbg_pkg`:
  - State enum.
  - DUMP_MAGIC = 8'hA5.
  - DUMP_WORDS = NREG+2.
  - Header field offsets.
- One sub-module, `dump_word_mux`: selects among header, PC and register data into the output holding register, indexed by state. It is small but keeps the FSM clean.
- Counters and the FSM live in the top module.

Test Plan:
- Preload x1..x31 = 100+i, `pc_i`=0x40, pulse `snap_i`, `tx_ready_i`=1 → header 0xA5000000, then 0x40, 0, 101..131. `tx_last_o` only on x31. `halt_o` high for exactly 34 cycles.
- Random `tx_ready_i` (about 50% duty) → same 34 words in order. Data is stable during every stall cycle. No duplicated or skipped words.
- Pulse `snap_i` 3 times mid-frame → second frame header 0xA5030001. Then hold `snap_i` high for 300 frame cycles → drop saturates at 0xFF.
- Force seq to 0xFFFF and run 2 frames → headers show seq 0xFFFF then 0x0000.
- Assert `rst_n_i`=0 at word 10 → `tx_valid_o`/`halt_o` fall without a clock edge. The next frame header is 0xA5000000.
- `snap_i` coincident with the header transfer → next frame header drop field = 1.
